// File: rtl/axi4_lite_usr_timeout_guard.sv
// ---------------------------------------------------------------------------
// axi4_lite_usr_timeout_guard
//
// Purpose:
//   Pass-through guard between the AXI4-Lite bridge user port (s_axi_usr_*)
//   and the user DUT (m_axi_usr_*). One read and one write may be outstanding
//   at a time, independently. If the DUT does not answer a transaction within
//   TIMEOUT_CYCLES, the guard answers upstream with SLVERR, marks that channel
//   faulted (sticky), records the faulting address and stops forwarding on the
//   faulted channel until clear_fault.
//
// Ports:
//   axi_aclk, axi_areset     clock, asynchronous active-high reset
//   s_axi_usr_aw/w/b/ar/r*   upstream AXI4-Lite slave side
//   m_axi_usr_aw/w/b/ar/r*   downstream AXI4-Lite master side (to the DUT)
//   clear_fault              single-cycle pulse clearing both fault flags
//   wr_fault, rd_fault       sticky per-channel timeout flags
//   fault_addr               address of the most recent timed-out transaction
// ---------------------------------------------------------------------------
module axi4_lite_usr_timeout_guard #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s_axi_usr_awaddr,
    input  logic [2:0]                s_axi_usr_awprot,
    input  logic                      s_axi_usr_awvalid,
    output logic                      s_axi_usr_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_usr_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_usr_wstrb,
    input  logic                      s_axi_usr_wvalid,
    output logic                      s_axi_usr_wready,
    output logic [1:0]                s_axi_usr_bresp,
    output logic                      s_axi_usr_bvalid,
    input  logic                      s_axi_usr_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_usr_araddr,
    input  logic [2:0]                s_axi_usr_arprot,
    input  logic                      s_axi_usr_arvalid,
    output logic                      s_axi_usr_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_usr_rdata,
    output logic [1:0]                s_axi_usr_rresp,
    output logic                      s_axi_usr_rvalid,
    input  logic                      s_axi_usr_rready,
    output logic [ADDR_WIDTH-1:0]     m_axi_usr_awaddr,
    output logic [2:0]                m_axi_usr_awprot,
    output logic                      m_axi_usr_awvalid,
    input  logic                      m_axi_usr_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_usr_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_usr_wstrb,
    output logic                      m_axi_usr_wvalid,
    input  logic                      m_axi_usr_wready,
    input  logic [1:0]                m_axi_usr_bresp,
    input  logic                      m_axi_usr_bvalid,
    output logic                      m_axi_usr_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_usr_araddr,
    output logic [2:0]                m_axi_usr_arprot,
    output logic                      m_axi_usr_arvalid,
    input  logic                      m_axi_usr_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_usr_rdata,
    input  logic [1:0]                m_axi_usr_rresp,
    input  logic                      m_axi_usr_rvalid,
    output logic                      m_axi_usr_rready,
    input  logic                      clear_fault,
    output logic                      wr_fault,
    output logic                      rd_fault,
    output logic [ADDR_WIDTH-1:0]     fault_addr
);

    typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_RESP} wrState_e;
    typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_RESP} rdState_e;

    localparam bit          C_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] C_TO_LAST = TIMEOUT_CYCLES - 32'd1;

    wrState_e r_wrState, w_wrNext;
    rdState_e r_rdState, w_rdNext;

    logic                    r_awHeld, r_wHeld;
    logic [ADDR_WIDTH-1:0]   r_awAddr, r_arAddr, r_faultAddr;
    logic [2:0]              r_awProt, r_arProt;
    logic [DATA_WIDTH-1:0]   r_wData, r_rData;
    logic [DATA_WIDTH/8-1:0] r_wStrb;
    logic                    r_mAwValid, r_mWValid, r_mArValid;
    logic [1:0]              r_bResp, r_rResp;
    logic [31:0]             r_wrTimer, r_rdTimer;
    logic                    r_wrFault, r_rdFault;

    logic w_sAwReady, w_sWReady, w_sBValid, w_mBReady;
    logic w_sArReady, w_sRValid, w_mRReady;
    logic w_awHs, w_wHs, w_wrStart, w_mBHs, w_wrTimeout;
    logic w_arHs, w_mRHs, w_rdTimeout;

    // A write starts once both AW and W are held, counting a handshake
    // completing this very cycle so no idle cycle is wasted.
    assign w_awHs      = s_axi_usr_awvalid && w_sAwReady;
    assign w_wHs       = s_axi_usr_wvalid && w_sWReady;
    assign w_wrStart   = (r_wrState == WR_IDLE) && (r_awHeld || w_awHs) && (r_wHeld || w_wHs);
    assign w_mBHs      = (r_wrState == WR_FWD) && m_axi_usr_bvalid;
    // A response arriving in the expiry cycle takes precedence over the timeout.
    assign w_wrTimeout = C_TO_EN && (r_wrState == WR_FWD) && (r_wrTimer == C_TO_LAST)
                         && !m_axi_usr_bvalid;

    assign w_arHs      = s_axi_usr_arvalid && w_sArReady;
    assign w_mRHs      = (r_rdState == RD_FWD) && m_axi_usr_rvalid;
    assign w_rdTimeout = C_TO_EN && (r_rdState == RD_FWD) && (r_rdTimer == C_TO_LAST)
                         && !m_axi_usr_rvalid;

    // Write FSM state register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) r_wrState <= WR_IDLE;
        else            r_wrState <= w_wrNext;
    end

    // Write FSM next state; a faulted channel answers locally without forwarding
    always_comb begin
        w_wrNext = r_wrState;
        unique case (r_wrState)
            WR_IDLE: if (w_wrStart) w_wrNext = r_wrFault ? WR_RESP : WR_FWD;
            WR_FWD:  if (w_mBHs || w_wrTimeout) w_wrNext = WR_RESP;
            WR_RESP: if (s_axi_usr_bready) w_wrNext = WR_IDLE;
            default: w_wrNext = WR_IDLE;
        endcase
    end

    // Write FSM outputs; bready stays high while faulted to swallow stray responses
    always_comb begin
        w_sAwReady = 1'b0;
        w_sWReady  = 1'b0;
        w_sBValid  = 1'b0;
        w_mBReady  = r_wrFault;
        unique case (r_wrState)
            WR_IDLE: begin
                w_sAwReady = !r_awHeld;
                w_sWReady  = !r_wHeld;
            end
            WR_FWD:  w_mBReady = 1'b1;
            WR_RESP: w_sBValid = 1'b1;
            default: ;
        endcase
    end

    // Write datapath: holding registers, downstream valids, timer and response
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_awHeld   <= 1'b0;
            r_wHeld    <= 1'b0;
            r_awAddr   <= '0;
            r_awProt   <= '0;
            r_wData    <= '0;
            r_wStrb    <= '0;
            r_mAwValid <= 1'b0;
            r_mWValid  <= 1'b0;
            r_wrTimer  <= '0;
            r_bResp    <= 2'b00;
        end else begin
            if (w_awHs) begin
                r_awHeld <= 1'b1;
                r_awAddr <= s_axi_usr_awaddr;
                r_awProt <= s_axi_usr_awprot;
            end
            if (w_wHs) begin
                r_wHeld <= 1'b1;
                r_wData <= s_axi_usr_wdata;
                r_wStrb <= s_axi_usr_wstrb;
            end
            if (w_wrStart && !r_wrFault) begin
                r_mAwValid <= 1'b1;
                r_mWValid  <= 1'b1;
                r_wrTimer  <= '0;
            end else if (r_wrState == WR_FWD) begin
                r_wrTimer <= r_wrTimer + 32'd1;
                if (m_axi_usr_awready || w_mBHs || w_wrTimeout) r_mAwValid <= 1'b0;
                if (m_axi_usr_wready || w_mBHs || w_wrTimeout)  r_mWValid  <= 1'b0;
            end
            if (w_mBHs)
                r_bResp <= m_axi_usr_bresp;
            else if (w_wrTimeout || (w_wrStart && r_wrFault))
                r_bResp <= 2'b10;
            if ((r_wrState == WR_RESP) && s_axi_usr_bready) begin
                r_awHeld <= 1'b0;
                r_wHeld  <= 1'b0;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) r_rdState <= RD_IDLE;
        else            r_rdState <= w_rdNext;
    end

    // Read FSM next state; AR is taken straight from IDLE, no holding stage
    always_comb begin
        w_rdNext = r_rdState;
        unique case (r_rdState)
            RD_IDLE: if (w_arHs) w_rdNext = r_rdFault ? RD_RESP : RD_FWD;
            RD_FWD:  if (w_mRHs || w_rdTimeout) w_rdNext = RD_RESP;
            RD_RESP: if (s_axi_usr_rready) w_rdNext = RD_IDLE;
            default: w_rdNext = RD_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        w_sArReady = 1'b0;
        w_sRValid  = 1'b0;
        w_mRReady  = r_rdFault;
        unique case (r_rdState)
            RD_IDLE: w_sArReady = 1'b1;
            RD_FWD:  w_mRReady  = 1'b1;
            RD_RESP: w_sRValid  = 1'b1;
            default: ;
        endcase
    end

    // Read datapath: address capture, downstream valid, timer and response
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_arAddr   <= '0;
            r_arProt   <= '0;
            r_mArValid <= 1'b0;
            r_rdTimer  <= '0;
            r_rData    <= '0;
            r_rResp    <= 2'b00;
        end else begin
            if (w_arHs) begin
                r_arAddr <= s_axi_usr_araddr;
                r_arProt <= s_axi_usr_arprot;
                if (r_rdFault) begin
                    r_rData <= '0;
                    r_rResp <= 2'b10;
                end else begin
                    r_mArValid <= 1'b1;
                    r_rdTimer  <= '0;
                end
            end else if (r_rdState == RD_FWD) begin
                r_rdTimer <= r_rdTimer + 32'd1;
                if (m_axi_usr_arready || w_mRHs || w_rdTimeout) r_mArValid <= 1'b0;
                if (w_mRHs) begin
                    r_rData <= m_axi_usr_rdata;
                    r_rResp <= m_axi_usr_rresp;
                end else if (w_rdTimeout) begin
                    r_rData <= '0;
                    r_rResp <= 2'b10;
                end
            end
        end
    end

    // Sticky faults: a timeout in the same cycle as clear_fault keeps the flag.
    // When both channels expire together the write address is reported.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_wrFault   <= 1'b0;
            r_rdFault   <= 1'b0;
            r_faultAddr <= '0;
        end else begin
            if (w_wrTimeout)      r_wrFault <= 1'b1;
            else if (clear_fault) r_wrFault <= 1'b0;
            if (w_rdTimeout)      r_rdFault <= 1'b1;
            else if (clear_fault) r_rdFault <= 1'b0;
            if (w_wrTimeout)      r_faultAddr <= r_awAddr;
            else if (w_rdTimeout) r_faultAddr <= r_arAddr;
        end
    end

    assign s_axi_usr_awready = w_sAwReady;
    assign s_axi_usr_wready  = w_sWReady;
    assign s_axi_usr_bvalid  = w_sBValid;
    assign s_axi_usr_bresp   = r_bResp;
    assign s_axi_usr_arready = w_sArReady;
    assign s_axi_usr_rvalid  = w_sRValid;
    assign s_axi_usr_rdata   = r_rData;
    assign s_axi_usr_rresp   = r_rResp;

    assign m_axi_usr_awaddr  = r_awAddr;
    assign m_axi_usr_awprot  = r_awProt;
    assign m_axi_usr_awvalid = r_mAwValid;
    assign m_axi_usr_wdata   = r_wData;
    assign m_axi_usr_wstrb   = r_wStrb;
    assign m_axi_usr_wvalid  = r_mWValid;
    assign m_axi_usr_bready  = w_mBReady;
    assign m_axi_usr_araddr  = r_arAddr;
    assign m_axi_usr_arprot  = r_arProt;
    assign m_axi_usr_arvalid = r_mArValid;
    assign m_axi_usr_rready  = w_mRReady;

    assign wr_fault   = r_wrFault;
    assign rd_fault   = r_rdFault;
    assign fault_addr = r_faultAddr;

endmodule
